// File: rtl/sram_1rw1r_param_if.sv
// Request/response bundle for the 1RW+1R SRAM model.
// master = requester side, slave = memory side.
interface sram_1rw1r_param_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int WMASK_WIDTH = 8
);
  localparam int NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH;

  logic                  ready;
  logic                  csb0;
  logic                  web0;
  logic [NUM_WMASKS-1:0] wmask0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] dout0;
  logic                  dout0_valid;
  logic                  csb1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] dout1;
  logic                  dout1_valid;
  logic                  collision;

  modport master (
    input  ready, dout0, dout0_valid, dout1, dout1_valid, collision,
    output csb0, web0, wmask0, addr0, din0, csb1, addr1
  );

  modport slave (
    output ready, dout0, dout0_valid, dout1, dout1_valid, collision,
    input  csb0, web0, wmask0, addr0, din0, csb1, addr1
  );
endinterface

// File: rtl/sram_1rw1r_param.sv
// Behavioural 1RW+1R SRAM: lane-masked writes on port0, write-first
// forwarding to port1 with a collision flag, optional output register,
// and a scrub sequence after reset that zeroes every word before ready.
module sram_1rw1r_param #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 9,
  parameter int WMASK_WIDTH    = 8,
  parameter int OUT_REG        = 0,
  parameter int SCRUB_ON_RESET = 1
) (
  input logic               clk,
  input logic               rst_n,
  sram_1rw1r_param_if.slave bus
);
  localparam int NUM_WMASKS = DATA_WIDTH / WMASK_WIDTH;
  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;
  localparam int STAGES     = (OUT_REG != 0) ? 2 : 1;

  generate
    if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_mask
      $error("sram_1rw1r_param: DATA_WIDTH must be a multiple of WMASK_WIDTH");
    end
  endgenerate

  typedef enum logic {SCRUB, RUN} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  ready;
  logic                  scrub_en;
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  wr0, rd0, rd1, hit;
  logic [DATA_WIDTH-1:0] rd0_word, rd1_word;

  logic [STAGES:1]                 vld0_pipe, vld1_pipe, col_pipe;
  logic [STAGES:1][DATA_WIDTH-1:0] d0_pipe, d1_pipe;

  // Scrub sequencing: walk cnt over the whole array, then park in RUN.
  always_comb begin
    state_next = state;
    scrub_en   = 1'b0;
    if (state == SCRUB) begin
      scrub_en = 1'b1;
      if (&cnt) state_next = RUN;
    end
  end

  // State, scrub counter and registered ready (high from the last scrub edge).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= (SCRUB_ON_RESET != 0) ? SCRUB : RUN;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_next;
      if (scrub_en) cnt <= cnt + 1'b1;
      ready <= (state_next == RUN);
    end
  end

  // Requests only count when ready was already high at the sampling edge.
  assign wr0 = rst_n & ready & ~bus.csb0 & ~bus.web0;
  assign rd0 = rst_n & ready & ~bus.csb0 &  bus.web0;
  assign rd1 = rst_n & ready & ~bus.csb1;

  // Array update: scrub zeroes, otherwise lane-masked port0 write.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (scrub_en) begin
        mem[cnt] <= '0;
      end else if (wr0) begin
        for (int i = 0; i < NUM_WMASKS; i++)
          if (bus.wmask0[i])
            mem[bus.addr0][i*WMASK_WIDTH +: WMASK_WIDTH] <= bus.din0[i*WMASK_WIDTH +: WMASK_WIDTH];
      end
    end
  end

  // Read words; port1 sees the post-write word on a same-address write.
  always_comb begin
    rd0_word = mem[bus.addr0];
    rd1_word = mem[bus.addr1];
    hit      = wr0 & rd1 & (bus.addr0 == bus.addr1);
    if (hit) begin
      for (int i = 0; i < NUM_WMASKS; i++)
        if (bus.wmask0[i])
          rd1_word[i*WMASK_WIDTH +: WMASK_WIDTH] = bus.din0[i*WMASK_WIDTH +: WMASK_WIDTH];
    end
  end

  // First read stage; data registers only load on a read so outputs hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld0_pipe[1] <= 1'b0;
      vld1_pipe[1] <= 1'b0;
      col_pipe[1]  <= 1'b0;
      d0_pipe[1]   <= '0;
      d1_pipe[1]   <= '0;
    end else begin
      vld0_pipe[1] <= rd0;
      vld1_pipe[1] <= rd1;
      col_pipe[1]  <= hit;
      if (rd0) d0_pipe[1] <= rd0_word;
      if (rd1) d1_pipe[1] <= rd1_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      // Optional output stage: one extra edge, still one result per clk.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld0_pipe[2] <= 1'b0;
          vld1_pipe[2] <= 1'b0;
          col_pipe[2]  <= 1'b0;
          d0_pipe[2]   <= '0;
          d1_pipe[2]   <= '0;
        end else begin
          vld0_pipe[2] <= vld0_pipe[1];
          vld1_pipe[2] <= vld1_pipe[1];
          col_pipe[2]  <= col_pipe[1];
          if (vld0_pipe[1]) d0_pipe[2] <= d0_pipe[1];
          if (vld1_pipe[1]) d1_pipe[2] <= d1_pipe[1];
        end
      end
    end
  endgenerate

  assign bus.ready       = ready;
  assign bus.dout0       = d0_pipe[STAGES];
  assign bus.dout0_valid = vld0_pipe[STAGES];
  assign bus.dout1       = d1_pipe[STAGES];
  assign bus.dout1_valid = vld1_pipe[STAGES];
  assign bus.collision   = col_pipe[STAGES];
endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Directed bench: instance A is 32/8 with latency 1, instance B is
// 64/16 with the output register (latency 2). Both share clock and reset.
module tb_sram_1rw1r_param;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   rise_a, rise_b;

  always #5 clk = ~clk;

  sram_1rw1r_param_if #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WMASK_WIDTH(8))  bus_a ();
  sram_1rw1r_param_if #(.DATA_WIDTH(64), .ADDR_WIDTH(9), .WMASK_WIDTH(16)) bus_b ();

  sram_1rw1r_param #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .WMASK_WIDTH(8),
                     .OUT_REG(0), .SCRUB_ON_RESET(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

  sram_1rw1r_param #(.DATA_WIDTH(64), .ADDR_WIDTH(9), .WMASK_WIDTH(16),
                     .OUT_REG(1), .SCRUB_ON_RESET(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_a;
    bus_a.csb0 = 1'b1; bus_a.web0 = 1'b1; bus_a.wmask0 = '0;
    bus_a.addr0 = '0;  bus_a.din0 = '0;   bus_a.csb1 = 1'b1; bus_a.addr1 = '0;
  endtask

  task automatic idle_b;
    bus_b.csb0 = 1'b1; bus_b.web0 = 1'b1; bus_b.wmask0 = '0;
    bus_b.addr0 = '0;  bus_b.din0 = '0;   bus_b.csb1 = 1'b1; bus_b.addr1 = '0;
  endtask

  task automatic wr_a(input logic [8:0] a, input logic [31:0] d, input logic [3:0] m);
    bus_a.csb0 = 1'b0; bus_a.web0 = 1'b0; bus_a.addr0 = a; bus_a.din0 = d; bus_a.wmask0 = m;
  endtask

  task automatic rd0_a(input logic [8:0] a);
    bus_a.csb0 = 1'b0; bus_a.web0 = 1'b1; bus_a.addr0 = a;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_a();
    idle_b();
    repeat (3) tick();

    // Reset state
    chk("rst_ready_a", bus_a.ready, 0);
    chk("rst_dout0_a", bus_a.dout0, 0);
    chk("rst_dout1_a", bus_a.dout1, 0);
    chk("rst_v0_a",    bus_a.dout0_valid, 0);
    chk("rst_v1_a",    bus_a.dout1_valid, 0);
    chk("rst_col_a",   bus_a.collision, 0);
    chk("rst_ready_b", bus_b.ready, 0);

    // Release, then reset again at scrub count 100
    rst_n = 1'b1;
    for (int i = 1; i <= 100; i++) tick();
    chk("mid_scrub_ready", bus_a.ready, 0);
    rst_n = 1'b0;
    tick();
    tick();
    chk("reset_mid_scrub_ready", bus_a.ready, 0);
    rst_n = 1'b1;

    // Count edges to ready; issue ignored requests part way through
    rise_a = 0;
    rise_b = 0;
    for (int i = 1; i <= 600 && (rise_a == 0 || rise_b == 0); i++) begin
      if (i == 200) begin
        wr_a(9'h005, 32'hFFFF_FFFF, 4'hF);
        bus_a.csb1 = 1'b0; bus_a.addr1 = 9'h005;
      end else begin
        idle_a();
      end
      tick();
      if (i == 200) begin
        chk("scrub_req_v0", bus_a.dout0_valid, 0);
        chk("scrub_req_v1", bus_a.dout1_valid, 0);
      end
      if (bus_a.ready && rise_a == 0) rise_a = i;
      if (bus_b.ready && rise_b == 0) rise_b = i;
    end
    chk("scrub_len_a", 64'(rise_a), 64'd512);
    chk("scrub_len_b", 64'(rise_b), 64'd512);

    // Top word zeroed; scrub-time write to 0x005 must not have landed
    idle_a();
    rd0_a(9'h005);
    bus_a.csb1 = 1'b0; bus_a.addr1 = 9'h1FF;
    tick();
    idle_a();
    chk("t1_v1",      bus_a.dout1_valid, 1);
    chk("t1_dout1",   bus_a.dout1, 0);
    chk("t6_v0",      bus_a.dout0_valid, 1);
    chk("t6_dout0",   bus_a.dout0, 0);

    // Masked writes on both instances, then read
    wr_a(9'h010, 32'hDEAD_BEEF, 4'b1111);
    bus_b.csb0 = 1'b0; bus_b.web0 = 1'b0; bus_b.addr0 = 9'h010;
    bus_b.din0 = 64'hDEAD_BEEF_CAFE_F00D; bus_b.wmask0 = 4'b1111;
    tick();
    wr_a(9'h010, 32'h1122_3344, 4'b0101);
    bus_b.din0 = 64'h1122_3344_5566_7788; bus_b.wmask0 = 4'b0101;
    tick();
    chk("wr_no_v0_a", bus_a.dout0_valid, 0);
    rd0_a(9'h010);
    bus_b.csb0 = 1'b0; bus_b.web0 = 1'b1; bus_b.addr0 = 9'h010;
    tick();
    idle_a();
    idle_b();
    chk("t2_v0_a",    bus_a.dout0_valid, 1);
    chk("t2_dout0_a", bus_a.dout0, 32'hDE22_BE44);
    chk("t2_v0_b_lat1", bus_b.dout0_valid, 0);
    tick();
    chk("t2_v0_a_pulse", bus_a.dout0_valid, 0);
    chk("t2_dout0_a_hold", bus_a.dout0, 32'hDE22_BE44);
    chk("t2_v0_b",    bus_b.dout0_valid, 1);
    chk("t2_dout0_b", bus_b.dout0, 64'hDEAD_3344_CAFE_7788);
    tick();
    chk("t2_v0_b_pulse", bus_b.dout0_valid, 0);

    // Back-to-back reads through the output register
    bus_b.csb0 = 1'b0; bus_b.web0 = 1'b1; bus_b.addr0 = 9'h010;
    tick();
    chk("b2b_e1_v", bus_b.dout0_valid, 0);
    bus_b.addr0 = 9'h011;
    tick();
    chk("b2b_e2_v", bus_b.dout0_valid, 1);
    chk("b2b_e2_d", bus_b.dout0, 64'hDEAD_3344_CAFE_7788);
    bus_b.addr0 = 9'h010;
    tick();
    idle_b();
    chk("b2b_e3_v", bus_b.dout0_valid, 1);
    chk("b2b_e3_d", bus_b.dout0, 0);
    tick();
    chk("b2b_e4_v", bus_b.dout0_valid, 1);
    chk("b2b_e4_d", bus_b.dout0, 64'hDEAD_3344_CAFE_7788);
    tick();
    chk("b2b_e5_v", bus_b.dout0_valid, 0);

    // Same-cycle write/read collision
    wr_a(9'h020, 32'hA5A5_A5A5, 4'b0011);
    bus_a.csb1 = 1'b0; bus_a.addr1 = 9'h020;
    tick();
    idle_a();
    chk("t3_v1",    bus_a.dout1_valid, 1);
    chk("t3_dout1", bus_a.dout1, 32'h0000_A5A5);
    chk("t3_col",   bus_a.collision, 1);
    tick();
    chk("t3_col_pulse", bus_a.collision, 0);
    chk("t3_v1_pulse",  bus_a.dout1_valid, 0);

    // Write then read next cycle: new data, no collision
    wr_a(9'h020, 32'h1234_5678, 4'b1100);
    tick();
    idle_a();
    bus_a.csb1 = 1'b0; bus_a.addr1 = 9'h020;
    tick();
    idle_a();
    chk("nxt_dout1", bus_a.dout1, 32'h1234_A5A5);
    chk("nxt_col",   bus_a.collision, 0);

    // wmask0 = 0 leaves the word alone
    wr_a(9'h020, 32'hFFFF_FFFF, 4'b0000);
    tick();
    idle_a();
    rd0_a(9'h020);
    tick();
    idle_a();
    chk("nomask_dout0", bus_a.dout0, 32'h1234_A5A5);

    // Streaming port1 reads 0x000..0x00F
    for (int i = 0; i < 16; i++) begin
      wr_a(9'(i), 32'hA000_0000 + 32'(i) * 32'h1111, 4'hF);
      tick();
    end
    idle_a();
    for (int i = 0; i < 16; i++) begin
      bus_a.csb1 = 1'b0; bus_a.addr1 = 9'(i);
      tick();
      chk($sformatf("stream_v[%0d]", i), bus_a.dout1_valid, 1);
      chk($sformatf("stream_d[%0d]", i), bus_a.dout1, 32'hA000_0000 + 32'(i) * 32'h1111);
    end
    idle_a();
    tick();
    chk("stream_end_v", bus_a.dout1_valid, 0);
    chk("stream_hold",  bus_a.dout1, 32'hA000_0000 + 32'd15 * 32'h1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
